// File: rtl/branch_flow_ctrl_pkg.sv
// Shared core package: opcodes, flow FSM states and 2-bit counter encodings.
// Included by branch_flow_ctrl and bht_table.
package branch_flow_ctrl_pkg;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic {
        RUN     = 1'b0,
        RECOVER = 1'b1
    } flow_state_t;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    function automatic logic [1:0] ctr_next(
        input logic [1:0] c,
        input logic       taken
    );
        logic [1:0] n;
        n = c;
        if (taken && c != ST) begin
            n = c + 2'd1;
        end else if (!taken && c != SNT) begin
            n = c - 2'd1;
        end
        return n;
    endfunction

endpackage

// File: rtl/bht_table.sv
// Branch history table: 2-bit saturating counters, async read, sync update.
// Every entry resets to weakly not-taken.
module bht_table
    import branch_flow_ctrl_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [IDX_W-1:0] i_rd_idx,
    output logic [1:0]       o_rd_ctr,
    input  logic             i_wr_en,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  logic             i_wr_taken
);

    logic [1:0] r_ctr [ENTRIES];

    // Read sees the pre-update value when indices collide.
    assign o_rd_ctr = r_ctr[i_rd_idx];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_ctr[i] <= WNT;
            end
        end else if (i_wr_en) begin
            r_ctr[i_wr_idx] <= ctr_next(r_ctr[i_wr_idx], i_wr_taken);
        end
    end

endmodule

// File: rtl/branch_flow_ctrl.sv
// Branch predict/resolve controller with registered mispredict redirect.
// Define BRANCH_FLOW_BHT_EN to enable the dynamic BHT predictor.
module branch_flow_ctrl
    import branch_flow_ctrl_pkg::*;
#(
    parameter int BHT_ENTRIES = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        id_valid,
    input  logic [31:0] id_pc,
    input  logic        id_is_branch,
    input  logic        id_is_jal,
    input  logic [31:0] id_target,
    output logic        id_pred_taken,
    output logic        id_redirect,
    output logic [31:0] id_redirect_pc,
    input  logic        ex_valid,
    input  logic        ex_is_ctrl,
    input  logic        ex_is_branch,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_target,
    input  logic        ex_pred_taken,
    input  logic        ex_pcsel,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        flush,
    output logic [31:0] br_count,
    output logic [31:0] mispred_count
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    flow_state_t r_state;
    flow_state_t w_state_nxt;
    logic [31:0] r_redirect_pc;
    logic [31:0] r_br_count;
    logic [31:0] r_mispred_count;
    logic        w_resolve;
    logic        w_mispredict;
    logic        w_bht_taken;

    assign w_resolve    = (r_state == RUN) && !stall && ex_valid && ex_is_ctrl;
    assign w_mispredict = w_resolve && (ex_pcsel != ex_pred_taken);

`ifdef BRANCH_FLOW_BHT_EN
    logic [1:0] w_rd_ctr;

    bht_table #(
        .ENTRIES (BHT_ENTRIES),
        .IDX_W   (IDX_W)
    ) u_bht (
        .clock      (clock),
        .reset      (reset),
        .i_rd_idx   (id_pc[IDX_W+1:2]),
        .o_rd_ctr   (w_rd_ctr),
        .i_wr_en    (w_resolve && ex_is_branch),
        .i_wr_idx   (ex_pc[IDX_W+1:2]),
        .i_wr_taken (ex_pcsel)
    );

    assign w_bht_taken = id_is_branch && w_rd_ctr[1];
`else
    // Static not-taken for conditional branches.
    assign w_bht_taken = 1'b0;
`endif

    assign id_pred_taken  = id_valid && (id_is_jal || w_bht_taken);
    assign id_redirect    = id_pred_taken && (r_state == RUN) && !stall;
    assign id_redirect_pc = id_target;

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            RUN: begin
                if (w_mispredict) begin
                    w_state_nxt = RECOVER;
                end
            end
            RECOVER: begin
                w_state_nxt = RUN;
            end
            default: begin
                w_state_nxt = RUN;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_redirect_pc <= '0;
        end else if (w_mispredict) begin
            r_redirect_pc <= ex_pcsel ? ex_target : ex_pc + 32'd4;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_br_count      <= '0;
            r_mispred_count <= '0;
        end else begin
            if (w_resolve && r_br_count != 32'hFFFF_FFFF) begin
                r_br_count <= r_br_count + 32'd1;
            end
            if (w_mispredict && r_mispred_count != 32'hFFFF_FFFF) begin
                r_mispred_count <= r_mispred_count + 32'd1;
            end
        end
    end

    assign redirect_valid = (r_state == RECOVER);
    assign flush          = (r_state == RECOVER);
    assign redirect_pc    = r_redirect_pc;
    assign br_count       = r_br_count;
    assign mispred_count  = r_mispred_count;

endmodule

// File: tb/tb_branch_flow_ctrl.sv
// Directed testbench for branch_flow_ctrl with immediate-assertion checks.
// Expectations follow BRANCH_FLOW_BHT_EN when it is defined.
module tb_branch_flow_ctrl;

`ifdef BRANCH_FLOW_BHT_EN
    localparam bit BHT_ON = 1'b1;
`else
    localparam bit BHT_ON = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        stall;
    logic        id_valid;
    logic [31:0] id_pc;
    logic        id_is_branch;
    logic        id_is_jal;
    logic [31:0] id_target;
    logic        id_pred_taken;
    logic        id_redirect;
    logic [31:0] id_redirect_pc;
    logic        ex_valid;
    logic        ex_is_ctrl;
    logic        ex_is_branch;
    logic [31:0] ex_pc;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic        ex_pcsel;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush;
    logic [31:0] br_count;
    logic [31:0] mispred_count;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    branch_flow_ctrl #(.BHT_ENTRIES(16)) dut (
        .clock          (clock),
        .reset          (reset),
        .stall          (stall),
        .id_valid       (id_valid),
        .id_pc          (id_pc),
        .id_is_branch   (id_is_branch),
        .id_is_jal      (id_is_jal),
        .id_target      (id_target),
        .id_pred_taken  (id_pred_taken),
        .id_redirect    (id_redirect),
        .id_redirect_pc (id_redirect_pc),
        .ex_valid       (ex_valid),
        .ex_is_ctrl     (ex_is_ctrl),
        .ex_is_branch   (ex_is_branch),
        .ex_pc          (ex_pc),
        .ex_target      (ex_target),
        .ex_pred_taken  (ex_pred_taken),
        .ex_pcsel       (ex_pcsel),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .flush          (flush),
        .br_count       (br_count),
        .mispred_count  (mispred_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic ex_set(input logic br, input logic [31:0] pc,
                          input logic [31:0] tgt, input logic pred,
                          input logic sel);
        ex_valid      = 1'b1;
        ex_is_ctrl    = 1'b1;
        ex_is_branch  = br;
        ex_pc         = pc;
        ex_target     = tgt;
        ex_pred_taken = pred;
        ex_pcsel      = sel;
    endtask

    task automatic ex_clr();
        ex_valid   = 1'b0;
        ex_is_ctrl = 1'b0;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0;
        id_valid = 1'b0; id_pc = '0; id_is_branch = 1'b0;
        id_is_jal = 1'b0; id_target = '0;
        ex_valid = 1'b0; ex_is_ctrl = 1'b0; ex_is_branch = 1'b0;
        ex_pc = '0; ex_target = '0; ex_pred_taken = 1'b0; ex_pcsel = 1'b0;
        step();
        step();
        reset = 1'b0;
        chk("rst_rv", {31'd0, redirect_valid}, 32'd0);
        chk("rst_flush", {31'd0, flush}, 32'd0);
        chk("rst_rpc", redirect_pc, 32'd0);
        chk("rst_br", br_count, 32'd0);
        chk("rst_mp", mispred_count, 32'd0);

        // Correctly predicted not-taken
        ex_set(1'b1, 32'h100, 32'h200, 1'b0, 1'b0);
        step();
        ex_clr();
        chk("nt_rv", {31'd0, redirect_valid}, 32'd0);
        chk("nt_br", br_count, 32'd1);
        chk("nt_mp", mispred_count, 32'd0);

        // Mispredict taken; EX held in RECOVER must be ignored
        ex_set(1'b1, 32'h100, 32'h200, 1'b0, 1'b1);
        step();
        id_valid = 1'b1; id_is_jal = 1'b1; id_target = 32'h7000;
        chk("mp_rv", {31'd0, redirect_valid}, 32'd1);
        chk("mp_flush", {31'd0, flush}, 32'd1);
        chk("mp_rpc", redirect_pc, 32'h200);
        chk("mp_cnt", mispred_count, 32'd1);
        chk("rec_idredir", {31'd0, id_redirect}, 32'd0);
        step();
        ex_clr();
        chk("rec_end_rv", {31'd0, redirect_valid}, 32'd0);
        chk("rec_end_flush", {31'd0, flush}, 32'd0);
        chk("rec_br", br_count, 32'd2);
        chk("rec_mp", mispred_count, 32'd1);

        // JAL in ID while RUN, then stalled
        chk("jal_pred", {31'd0, id_pred_taken}, 32'd1);
        chk("jal_redir", {31'd0, id_redirect}, 32'd1);
        chk("jal_rpc", id_redirect_pc, 32'h7000);
        stall = 1'b1;
        #1;
        chk("jal_stall", {31'd0, id_redirect}, 32'd0);
        stall = 1'b0;
        id_valid = 1'b0; id_is_jal = 1'b0;

        // Predicted taken, actually not taken: pc+4 wraps
        ex_set(1'b1, 32'hFFFF_FFFC, 32'h40, 1'b1, 1'b0);
        step();
        ex_clr();
        chk("wrap_rv", {31'd0, redirect_valid}, 32'd1);
        chk("wrap_rpc", redirect_pc, 32'h0);
        chk("wrap_mp", mispred_count, 32'd2);
        step();

        // Train pc 0x40 taken twice (correctly predicted, no redirect)
        ex_set(1'b1, 32'h40, 32'h80, 1'b1, 1'b1);
        step();
        step();
        ex_clr();
        chk("train_rv", {31'd0, redirect_valid}, 32'd0);
        chk("train_br", br_count, 32'd5);
        id_valid = 1'b1; id_is_branch = 1'b1;
        id_pc = 32'h40; id_target = 32'h1234;
        #1;
        chk("bht_pred", {31'd0, id_pred_taken}, {31'd0, BHT_ON});
        chk("bht_redir", {31'd0, id_redirect}, {31'd0, BHT_ON});
        chk("bht_rpc", id_redirect_pc, 32'h1234);
        id_valid = 1'b0; id_is_branch = 1'b0;

        // JALR resolves taken with not-taken prediction
        ex_set(1'b0, 32'h300, 32'h3000, 1'b0, 1'b1);
        step();
        ex_clr();
        chk("jalr_rv", {31'd0, redirect_valid}, 32'd1);
        chk("jalr_rpc", redirect_pc, 32'h3000);
        chk("jalr_mp", mispred_count, 32'd3);
        chk("jalr_br", br_count, 32'd6);
        step();

        // Reset during RECOVER drops the redirect
        ex_set(1'b1, 32'h500, 32'h600, 1'b0, 1'b1);
        step();
        ex_clr();
        reset = 1'b1;
        chk("rr_rv_pre", {31'd0, redirect_valid}, 32'd1);
        step();
        reset = 1'b0;
        chk("rr_rv", {31'd0, redirect_valid}, 32'd0);
        chk("rr_rpc", redirect_pc, 32'd0);
        chk("rr_br", br_count, 32'd0);
        step();
        chk("rr_rv2", {31'd0, redirect_valid}, 32'd0);

        // Stalled resolve: no counters, no BHT, no redirect
        stall = 1'b1;
        ex_set(1'b1, 32'h40, 32'h80, 1'b0, 1'b1);
        step();
        step();
        ex_clr();
        stall = 1'b0;
        chk("st_rv", {31'd0, redirect_valid}, 32'd0);
        chk("st_br", br_count, 32'd0);
        chk("st_mp", mispred_count, 32'd0);
        id_valid = 1'b1; id_is_branch = 1'b1; id_pc = 32'h40;
        #1;
        chk("st_bht", {31'd0, id_pred_taken}, 32'd0);
        id_valid = 1'b0; id_is_branch = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
